bcd_serial_adder: RTL and testbench

//   Multi-digit BCD adder. Digits are processed serially, one per clock,

---
 rtl/bcd_serial_adder.sv | 133 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Serial multi-digit BCD adder.
// It processes one digit per clock, least-significant digit first.
// Operands are accepted, and the result is returned, over valid/ready handshakes.
// Optional feature: define BCD_SUB_EN to add the sub port. When sub is set, the adder
// adds the nines complement of b, which gives a - b in tens complement.
module bcd_serial_adder #(
   parameter int unsigned NDIGITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NDIGITS-1:0]   a,
   input  logic [4*NDIGITS-1:0]   b,
   input  logic                   carry_in,
`ifdef BCD_SUB_EN
   input  logic                   sub,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NDIGITS-1:0]   sum,
   output logic                   carry_out,
   output logic                   digit_err
);

   localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NDIGITS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t                state;
   logic [4*NDIGITS-1:0]  a_q;
   logic [4*NDIGITS-1:0]  b_q;
   logic                  carry;
   logic [IW-1:0]         idx;
`ifdef BCD_SUB_EN
   logic                  sub_q;
`endif

   logic [3:0] a_dig;
   logic [3:0] b_dig;
   logic [3:0] b_eff;
   logic [4:0] t;
   logic [3:0] sum_dig;
   logic       carry_nxt;
   logic       dig_bad;

   // Single-digit BCD add of the digit selected by idx
   always_comb begin
      a_dig = a_q[4*idx +: 4];
      b_dig = b_q[4*idx +: 4];
`ifdef BCD_SUB_EN
      // Nines complement; illegal b digits wrap, but digit_err flags them anyway
      b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
`else
      b_eff = b_dig;
`endif
      t = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
      if (t > 5'd9) begin
         sum_dig   = t[3:0] + 4'd6;
         carry_nxt = 1'b1;
      end else begin
         sum_dig   = t[3:0];
         carry_nxt = 1'b0;
      end
      // Error detection uses the raw operands, not the complemented b
      dig_bad = (a_dig > 4'd9) | (b_dig > 4'd9);
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         digit_err <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
`ifdef BCD_SUB_EN
         sub_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  a_q       <= a;
                  b_q       <= b;
                  carry     <= carry_in;
`ifdef BCD_SUB_EN
                  sub_q     <= sub;
`endif
                  sum       <= '0;
                  digit_err <= 1'b0;
                  idx       <= '0;
                  in_ready  <= 1'b0;
                  state     <= StRun;
               end
            end
            StRun: begin
               sum[4*idx +: 4] <= sum_dig;
               carry           <= carry_nxt;
               digit_err       <= digit_err | dig_bad;
               if (idx == LastIdx) begin
                  // idx stays at the last digit so it never wraps
                  carry_out <= carry_nxt;
                  out_valid <= 1'b1;
                  state     <= StDone;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            StDone: begin
               // in_ready rises only after the handshake, so no same-cycle accept
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               state     <= StIdle;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder.
// It drives a 4-digit instance and a 1-digit instance.
// It compares their results against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

   localparam int unsigned ND = 4;
   localparam int unsigned W  = 4 * ND;
`ifdef BCD_SUB_EN
   localparam bit SubEn = 1'b1;
`else
   localparam bit SubEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-digit instance
   logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, derr;
   logic [W-1:0] a, b, sum;
   // 1-digit instance
   logic         in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, derr1;
   logic [3:0]   a1, b1, sum1;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_serial_adder #(.NDIGITS(ND)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (cin),
`ifdef BCD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (cout),
      .digit_err (derr)
   );

   bcd_serial_adder #(.NDIGITS(1)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .carry_in  (cin1),
`ifdef BCD_SUB_EN
      .sub       (sub1),
`endif
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .carry_out (cout1),
      .digit_err (derr1)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned pow10(input int n);
      longint unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic longint unsigned bcd2int(input logic [63:0] v, input int n);
      longint unsigned r = 0;
      for (int i = n - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [63:0] int2bcd(input longint unsigned v, input int n);
      logic [63:0] r = '0;
      longint unsigned x = v;
      for (int i = 0; i < n; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic has_bad(input logic [63:0] v, input int n);
      logic r = 1'b0;
      for (int i = 0; i < n; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   // Decimal reference: subtraction adds the nines complement of b (10^n - 1 - b)
   task automatic ref_op(input logic [63:0] aa, input logic [63:0] bb, input logic c,
                         input logic s, input int n, output logic [63:0] rs, output logic rc);
      longint unsigned p  = pow10(n);
      longint unsigned vb = bcd2int(bb, n);
      longint unsigned r;
      if (s) vb = p - 1 - vb;
      r  = bcd2int(aa, n) + vb + longint'(c);
      rc = (r >= p);
      rs = int2bcd(r % p, n);
   endtask

   task automatic run4(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c,
                       input logic s, input int hold, input bit chk_sum);
      logic [63:0] es;
      logic        ec;
      int          lat;
      ref_op(64'(aa), 64'(bb), c, s, ND, es, ec);
      out_ready = (hold == 0);
      for (int k = 0; k < 50 && !in_ready; k++) begin
         @(posedge clk); #1;
      end
      check_val("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1; a = aa; b = bb; cin = c; sub = s;
      @(posedge clk); #1;
      // Scramble operands after acceptance; they must not matter
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      check_val("in_ready_in_run", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("latency", lat, ND);
      if (chk_sum) begin
         check_val("sum", sum, es);
         check_val("carry_out", cout, ec);
      end
      check_val("digit_err", derr, has_bad(64'(aa), ND) | has_bad(64'(bb), ND));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check_val("stall_out_valid", out_valid, 1);
         check_val("stall_in_ready", in_ready, 0);
         if (chk_sum) begin
            check_val("stall_sum", sum, es);
            check_val("stall_carry_out", cout, ec);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_val("in_ready_after_done", in_ready, 1);
      check_val("out_valid_after_done", out_valid, 0);
   endtask

   task automatic run1(input logic [3:0] aa, input logic [3:0] bb, input logic c, input logic s);
      logic [63:0] es;
      logic        ec;
      int          lat;
      ref_op(64'(aa), 64'(bb), c, s, 1, es, ec);
      for (int k = 0; k < 50 && !in_ready1; k++) begin
         @(posedge clk); #1;
      end
      check_val("n1_in_ready", in_ready1, 1);
      in_valid1 = 1'b1; a1 = aa; b1 = bb; cin1 = c; sub1 = s;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("n1_latency", lat, 1);
      check_val("n1_sum", sum1, es);
      check_val("n1_carry_out", cout1, ec);
      check_val("n1_digit_err", derr1, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      bit           good;
      reset = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_in_ready", in_ready, 1);
      check_val("reset_out_valid", out_valid, 0);
      check_val("reset_sum", sum, 0);
      check_val("reset_carry_out", cout, 0);
      check_val("reset_digit_err", derr, 0);
      check_val("n1_reset_in_ready", in_ready1, 1);
      check_val("n1_reset_out_valid", out_valid1, 0);
      reset = 1'b0;

      // Directed cases
      run4(16'h1234, 16'h8766, 1'b0, 1'b0, 0, 1'b1);
      run4(16'h9999, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
      run4(16'h0A00, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      run4(16'h4567, 16'h5678, 1'b1, 1'b0, 5, 1'b1);
      if (SubEn) begin
         run4(16'h0500, 16'h0123, 1'b1, 1'b1, 0, 1'b1);
         run4(16'h0100, 16'h0200, 1'b1, 1'b1, 0, 1'b1);
      end

      // Reset while the operation is at digit index 2
      out_ready = 1'b1;
      in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_val("midrun_reset_in_ready", in_ready, 1);
      check_val("midrun_reset_out_valid", out_valid, 0);
      check_val("midrun_reset_sum", sum, 0);
      repeat (ND + 1) @(posedge clk);
      #1;
      check_val("midrun_no_result", out_valid, 0);
      run4(16'h0005, 16'h0005, 1'b0, 1'b0, 0, 1'b1);

      // Randomized operations; some carry an illegal digit
      for (int n = 0; n < 40; n++) begin
         for (int d = 0; d < ND; d++) begin
            ra[4*d +: 4] = 4'($urandom_range(0, 9));
            rb[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         good = ($urandom_range(0, 7) != 0);
         if (!good) begin
            if ($urandom_range(0, 1) == 0)
               ra[4*$urandom_range(0, ND - 1) +: 4] = 4'($urandom_range(10, 15));
            else
               rb[4*$urandom_range(0, ND - 1) +: 4] = 4'($urandom_range(10, 15));
         end
         run4(ra, rb, 1'($urandom), SubEn ? 1'($urandom) : 1'b0, $urandom_range(0, 2), good);
      end

      // Exhaustive single-digit check
      for (int s = 0; s <= int'(SubEn); s++)
         for (int x = 0; x < 10; x++)
            for (int y = 0; y < 10; y++)
               for (int c = 0; c < 2; c++)
                  run1(4'(x), 4'(y), 1'(c), 1'(s));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
